// File: rtl/keys_pio_debounced.sv
`default_nettype none
// ============================================================================
// Module   : keys_pio_debounced
// Function : Avalon-MM key input port: 2-flop synchroniser, per-bit debounce,
//            sticky edge capture and maskable level interrupt.
// Revision : 1.0  initial release
// ============================================================================
module keys_pio_debounced #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_MODE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [1:0] c_ADDR_DATA = 2'd0;
  localparam logic [1:0] c_ADDR_RAW  = 2'd1;
  localparam logic [1:0] c_ADDR_MASK = 2'd2;
  localparam logic [1:0] c_ADDR_CAP  = 2'd3;

  logic [WIDTH-1:0]              r_sync1;
  logic [WIDTH-1:0]              r_sync2;
  logic [WIDTH-1:0]              r_stable;
  logic [WIDTH-1:0]              r_stable_d;
  logic [WIDTH-1:0][c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]              r_irq_mask;
  logic [WIDTH-1:0]              r_edge_cap;
  logic [31:0]                   r_readdata;

  logic                          w_write;
  logic [WIDTH-1:0]              w_clear_mask;
  logic [WIDTH-1:0]              w_event;
  logic [31:0]                   w_rd_mux;

  assign w_write      = chipselect & ~write_n;
  assign w_clear_mask = (w_write && (address == c_ADDR_CAP)) ? writedata[WIDTH-1:0] : '0;

  // The synchroniser resets to the idle level so reset release never looks like a key press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_stable <= RESET_LEVEL;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == c_CNT_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable_d <= RESET_LEVEL;
    end else begin
      r_stable_d <= r_stable;
    end
  end

  if (EDGE_MODE == 0) begin : g_edge_rise
    assign w_event = r_stable & ~r_stable_d;
  end else if (EDGE_MODE == 1) begin : g_edge_fall
    assign w_event = ~r_stable & r_stable_d;
  end else begin : g_edge_any
    assign w_event = r_stable ^ r_stable_d;
  end

  // OR-ing the event after the clear lets a coincident new edge survive a write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_cap <= '0;
      r_irq_mask <= '0;
    end else begin
      r_edge_cap <= (r_edge_cap & ~w_clear_mask) | w_event;
      if (w_write && (address == c_ADDR_MASK)) begin
        r_irq_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      c_ADDR_DATA: w_rd_mux[WIDTH-1:0] = r_stable;
      c_ADDR_RAW:  w_rd_mux[WIDTH-1:0] = r_sync2;
      c_ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
      default:     w_rd_mux[WIDTH-1:0] = r_edge_cap;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge_cap & r_irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_keys_pio_debounced.sv
`default_nettype none
// ============================================================================
// Module   : tb_keys_pio_debounced
// Function : Self-checking bench for keys_pio_debounced (4 keys, 4-cycle debounce).
// Revision : 1.0  initial release
// ============================================================================
module tb_keys_pio_debounced;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state, held in terms of what each key has done rather than flop stages.
  logic [3:0]  m_sync1, m_sync2, m_stable, m_fell, m_mask, m_cap;
  logic [31:0] m_rdata;
  int          m_run [4];

  keys_pio_debounced #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .EDGE_MODE      (1),
    .RESET_LEVEL    (4'hF)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync1 = 4'hF;
    m_sync2 = 4'hF;
    m_stable = 4'hF;
    m_fell = 4'h0;
    m_mask = 4'h0;
    m_cap = 4'h0;
    m_rdata = 32'h0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  // Advances the reference across the coming rising edge using the inputs now applied.
  task automatic model_step();
    logic [3:0] nxt;
    logic [3:0] clr;
    logic       wr;
    wr = chipselect && !write_n;
    case (address)
      2'd0:    m_rdata = {28'h0, m_stable};
      2'd1:    m_rdata = {28'h0, m_sync2};
      2'd2:    m_rdata = {28'h0, m_mask};
      default: m_rdata = {28'h0, m_cap};
    endcase
    clr   = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
    m_cap = (m_cap & ~clr) | m_fell;
    if (wr && address == 2'd2) m_mask = writedata[3:0];
    nxt = m_stable;
    for (int i = 0; i < 4; i++) begin
      if (m_sync2[i] != m_stable[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DEB) begin
          nxt[i]   = m_sync2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_fell   = m_stable & ~nxt;
    m_stable = nxt;
    m_sync2  = m_sync1;
    m_sync1  = in_port;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        model_reset();
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
      end else begin
        check("model_readdata", readdata, m_rdata);
        check("model_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
        model_step();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    tick();
    check(name, readdata, exp);
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 4'hF;
    wait_ticks(3);
    reset_n = 1'b1;

    // Post-reset register contents
    read_check("rst_data", 2'd0, 32'h0000_000F);
    read_check("rst_raw", 2'd1, 32'h0000_000F);
    read_check("rst_mask", 2'd2, 32'h0000_0000);
    read_check("rst_cap", 2'd3, 32'h0000_0000);
    check("rst_irq_lit", {31'h0, irq}, 32'h0);

    // Key 0 pressed and held
    bus_write(2'd2, 32'h1);
    in_port = 4'hE;
    address = 2'd0;
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 5) check("press_irq_e5", {31'h0, irq}, 32'h0);
      if (k == 6) begin
        check("press_irq_e6", {31'h0, irq}, 32'h1);
        check("press_data_e6", readdata, 32'h0000_000E);
      end
    end
    read_check("press_cap", 2'd3, 32'h0000_0001);

    // Key 1 bounces: 3 low, 1 high, 3 low -> never accepted
    in_port = 4'hC;
    address = 2'd1;
    for (int j = 0; j < 3; j++) begin
      tick();
      if (j == 2) check("bounce_raw", readdata, 32'h0000_000C);
    end
    in_port = 4'hE;
    tick();
    in_port = 4'hC;
    wait_ticks(3);
    in_port = 4'hE;
    wait_ticks(8);
    read_check("bounce_data", 2'd0, 32'h0000_000E);
    read_check("bounce_cap", 2'd3, 32'h0000_0001);

    // Clear coincident with a new falling event on key 0
    in_port = 4'hF;
    wait_ticks(8);
    in_port = 4'hE;
    wait_ticks(6);
    bus_write(2'd3, 32'h1);
    check("coincide_irq", {31'h0, irq}, 32'h1);
    read_check("coincide_cap", 2'd3, 32'h0000_0001);
    bus_write(2'd3, 32'h1);
    check("clear_irq", {31'h0, irq}, 32'h0);
    read_check("clear_cap", 2'd3, 32'h0000_0000);

    // Masked-off event on key 2, then unmask
    bus_write(2'd2, 32'h0);
    in_port = 4'hA;
    wait_ticks(8);
    read_check("masked_cap", 2'd3, 32'h0000_0004);
    check("masked_irq", {31'h0, irq}, 32'h0);
    bus_write(2'd2, 32'h4);
    check("unmask_irq", {31'h0, irq}, 32'h1);

    // Asynchronous reset during a debounce count
    in_port = 4'h0;
    address = 2'd0;
    wait_ticks(3);
    reset_n = 1'b0;
    #1;
    check("async_rst_readdata", readdata, 32'h0);
    check("async_rst_irq", {31'h0, irq}, 32'h0);
    wait_ticks(2);
    reset_n = 1'b1;
    read_check("release_data", 2'd0, 32'h0000_000F);
    wait_ticks(8);
    read_check("settle_data", 2'd0, 32'h0000_0000);
    read_check("settle_cap", 2'd3, 32'h0000_000F);

    wait_ticks(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
